// File: rtl/prng_bank.sv
// prng_bank: bank of independent Galois LFSRs with entropy mixing and fresh-word handshake.
// Optional output whitening is enabled by defining PRNG_BANK_WHITEN_EN.
module prng_bank #(
    parameter int CHANNELS   = 4,
    parameter int STATE_BITS = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int INDEX_BASE = 0,
    parameter logic [CHANNELS*STATE_BITS-1:0] POLYS = {CHANNELS{32'h80000062}},
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          step_en,
    input  logic [CHANNELS-1:0]           entropy,
    input  logic [CHANNELS-1:0]           rd_en,
    output logic [CHANNELS-1:0]           rd_valid,
    output logic [CHANNELS*OUT_WIDTH-1:0] rd_data,
    input  logic                          cfg_we,
    input  logic [SEL_W-1:0]              cfg_sel,
    input  logic [STATE_BITS-1:0]         cfg_poly,
    input  logic [STATE_BITS-1:0]         cfg_seed
);

    localparam int FW = $clog2(OUT_WIDTH + 1);
    localparam logic [FW-1:0] FRESH_FULL = FW'(OUT_WIDTH);
    localparam logic [STATE_BITS-1:0] ONE = STATE_BITS'(1);
    localparam logic [STATE_BITS-1:0] TOP_TAP = ONE << (STATE_BITS - 1);

    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("prng_bank: CHANNELS must be 1..16");
    end
    if (2 * OUT_WIDTH > STATE_BITS) begin : g_bad_width
        $error("prng_bank: 2*OUT_WIDTH must not exceed STATE_BITS");
    end

    logic [SEL_W-1:0] sel_in;
    logic [STATE_BITS-1:0] seed_in;

    assign sel_in  = cfg_sel;
    assign seed_in = (cfg_seed == '0) ? ONE : cfg_seed;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam logic [STATE_BITS-1:0] SEED_RAW =
            STATE_BITS'(INDEX_BASE + i + 1);
        localparam logic [STATE_BITS-1:0] SEED =
            (SEED_RAW == '0) ? ONE : SEED_RAW;
        localparam logic [STATE_BITS-1:0] POLY_RST =
            POLYS[i*STATE_BITS +: STATE_BITS];

        logic [STATE_BITS-1:0] state_q;
        logic [STATE_BITS-1:0] poly_q;
        logic [FW-1:0]         fresh_q;
        logic [STATE_BITS-1:0] shifted;
        logic [STATE_BITS-1:0] next_state;
        logic                  valid;
        logic                  rd_hit;
        logic                  cfg_hit;

        assign valid   = (fresh_q == FRESH_FULL);
        assign rd_hit  = rd_en[i] & valid;
        // Out-of-range selects never match any channel index, so they drop out here.
        assign cfg_hit = cfg_we && (sel_in == SEL_W'(i));

        always_comb begin
            shifted = state_q >> 1;
            if (state_q[0]) begin
                shifted = shifted ^ poly_q;
            end
            shifted[STATE_BITS-1] = shifted[STATE_BITS-1] ^ entropy[i];
            next_state = (shifted == '0) ? ONE : shifted;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= SEED;
                poly_q  <= POLY_RST;
                fresh_q <= '0;
            end else if (cfg_hit) begin
                state_q <= seed_in;
                poly_q  <= cfg_poly | TOP_TAP;
                fresh_q <= '0;
            end else begin
                if (step_en) begin
                    state_q <= next_state;
                end
                if (rd_hit) begin
                    fresh_q <= '0;
                end else if (step_en && !valid) begin
                    fresh_q <= fresh_q + FW'(1);
                end
            end
        end

        assign rd_valid[i] = valid;
`ifdef PRNG_BANK_WHITEN_EN
        assign rd_data[i*OUT_WIDTH +: OUT_WIDTH] =
            state_q[OUT_WIDTH-1:0] ^ state_q[2*OUT_WIDTH-1:OUT_WIDTH];
`else
        assign rd_data[i*OUT_WIDTH +: OUT_WIDTH] = state_q[OUT_WIDTH-1:0];
`endif
    end

endmodule
